// File: rtl/i2c_slave_regfile.sv
// I2C slave with a small byte-wide register file and an auto-incrementing
// register pointer. SDA is only ever pulled low through sda_oe, and the
// block never drives SCL. All bus decisions are made on synchronised copies
// of SCL/SDA, so the system clock must be at least 16x the SCL rate.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         ADDR_W     = 2,
    parameter logic [7:0] RST_VAL    = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_oe,
    output logic [(2**ADDR_W)*8-1:0]    regs_o,
    output logic                        wr_stb,
    output logic [ADDR_W-1:0]           wr_idx,
    output logic                        busy
);

    localparam int NREGS = 2**ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WR, S_WR_ACK, S_RD, S_RD_ACK
    } state_t;

    // Synchroniser and history flops for edge detection
    logic r_scl_s1, r_scl_s2, r_scl_h;
    logic r_sda_s1, r_sda_s2, r_sda_h;

    // Registered state
    state_t                       r_state;
    logic [2:0]                   r_bit_cnt;
    logic [7:0]                   r_shift;
    logic [ADDR_W-1:0]            r_ptr;
    logic [NREGS-1:0][7:0]        r_regs;
    logic                         r_sda_oe;
    logic                         r_busy;
    logic                         r_phase;   // ACK states: ACK driven; RD: bits being driven
    logic                         r_rw;
    logic                         r_wr_stb;
    logic [ADDR_W-1:0]            r_wr_idx;

    // Next-state values
    state_t                       w_state_nxt;
    logic [2:0]                   w_bit_cnt_nxt;
    logic [7:0]                   w_shift_nxt;
    logic [ADDR_W-1:0]            w_ptr_nxt;
    logic [NREGS-1:0][7:0]        w_regs_nxt;
    logic                         w_sda_oe_nxt;
    logic                         w_busy_nxt;
    logic                         w_phase_nxt;
    logic                         w_rw_nxt;
    logic                         w_wr_stb_nxt;
    logic [ADDR_W-1:0]            w_wr_idx_nxt;

    logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte;

    // Two-flop synchronisers plus a history flop on both bus lines
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;    r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
            r_sda_s1 <= sda_i;    r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_sda_rise = r_sda_s2 & ~r_sda_h;
    assign w_sda_fall = ~r_sda_s2 & r_sda_h;
    assign w_start    = w_sda_fall & r_scl_s2;
    assign w_stop     = w_sda_rise & r_scl_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};

    // Next-state and datapath decode; START/STOP override any bit event
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_regs_nxt    = r_regs;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_phase_nxt   = r_phase;
        w_rw_nxt      = r_rw;
        w_wr_stb_nxt  = 1'b0;
        w_wr_idx_nxt  = r_wr_idx;

        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 3'd7;
            w_sda_oe_nxt  = 1'b0;
            w_phase_nxt   = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            w_phase_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    if (r_bit_cnt == 3'd0) begin
                        if (w_byte[7:1] == SLAVE_ADDR) begin
                            w_state_nxt = S_ADDR_ACK;
                            w_busy_nxt  = 1'b1;
                            w_rw_nxt    = w_byte[0];
                            w_phase_nxt = 1'b0;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_busy_nxt   = 1'b0;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
                S_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sda_oe_nxt = 1'b1;
                        w_phase_nxt  = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = 3'd7;
                        if (r_rw) begin
                            // Read: MSB goes on the wire at the same fall that ends the ACK
                            w_state_nxt  = S_RD;
                            w_shift_nxt  = r_regs[r_ptr];
                            w_sda_oe_nxt = ~r_regs[r_ptr][7];
                            w_phase_nxt  = 1'b1;
                        end else begin
                            w_state_nxt  = S_PTR;
                            w_sda_oe_nxt = 1'b0;
                            w_phase_nxt  = 1'b0;
                        end
                    end
                end
                S_PTR: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    if (r_bit_cnt == 3'd0) begin
                        w_ptr_nxt   = w_byte[ADDR_W-1:0];
                        w_state_nxt = S_WR_ACK;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
                S_WR: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    if (r_bit_cnt == 3'd0) begin
                        w_regs_nxt[r_ptr] = w_byte;
                        w_wr_stb_nxt      = 1'b1;
                        w_wr_idx_nxt      = r_ptr;
                        w_ptr_nxt         = r_ptr + ADDR_W'(1);
                        w_state_nxt       = S_WR_ACK;
                        w_phase_nxt       = 1'b0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
                S_WR_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sda_oe_nxt = 1'b1;
                        w_phase_nxt  = 1'b1;
                    end else begin
                        w_sda_oe_nxt  = 1'b0;
                        w_phase_nxt   = 1'b0;
                        w_state_nxt   = S_WR;
                        w_bit_cnt_nxt = 3'd7;
                    end
                end
                S_RD: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sda_oe_nxt = ~r_shift[7];
                        w_phase_nxt  = 1'b1;
                    end else if (r_bit_cnt == 3'd0) begin
                        w_sda_oe_nxt = 1'b0;
                        w_ptr_nxt    = r_ptr + ADDR_W'(1);
                        w_state_nxt  = S_RD_ACK;
                        w_phase_nxt  = 1'b0;
                    end else begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_sda_oe_nxt  = ~r_shift[6];
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
                S_RD_ACK: if (w_scl_rise) begin
                    if (!r_sda_s2) begin
                        // Master ACK: next byte is driven from the following SCL fall
                        w_state_nxt   = S_RD;
                        w_shift_nxt   = r_regs[r_ptr];
                        w_bit_cnt_nxt = 3'd7;
                        w_phase_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register and datapath flops
    // NOTE: the register file is reset here because it is a handful of flops with a defined reset value, not a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_ptr     <= '0;
            r_regs    <= {NREGS{RST_VAL}};
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_phase   <= 1'b0;
            r_rw      <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_idx  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_regs    <= w_regs_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_phase   <= w_phase_nxt;
            r_rw      <= w_rw_nxt;
            r_wr_stb  <= w_wr_stb_nxt;
            r_wr_idx  <= w_wr_idx_nxt;
        end
    end

    assign sda_oe = r_sda_oe;
    assign regs_o = r_regs;
    assign wr_stb = r_wr_stb;
    assign wr_idx = r_wr_idx;
    assign busy   = r_busy;

endmodule
